// File: rtl/regfile_wb_arb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default register address / data widths
//   STAT_W                  : width of each per-requester beat counter
//   arb_state_e             : arbiter FSM encoding (IDLE=0, OWNED=1)
//   idx_w()                 : index width for a given requester count
package regfile_wb_arb_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int STAT_W     = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   valid     : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot grant (all zero when nothing is valid)
//   grant_idx : binary index of the granted requester (0 when none)
module rr_arbiter
  import regfile_wb_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);
  logic found;
  int   j;

  // Scan cyclically from ptr; the wrap is explicit so NUM_REQ need not be a power of 2.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && valid[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register_file write port among NUM_REQ writeback sources.
// Round-robin between bursts; a burst (beats until req_last) locks the port to its owner.
// Handshake: a beat of requester i transfers in any cycle where req_valid[i] && req_ready[i];
// req_ready is combinational from state/owner/rr_ptr/req_valid, at most one bit is high,
// and it is forced low while reset is asserted so no beat is taken during reset.
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_last [NUM_REQ], req_addr/req_data flat (slice i = [i*W +: W])
//   req_ready [NUM_REQ]                 : accept strobe per requester
//   write_enable/write_at_addr/write_data : registered write port, 1-cycle latency
//   busy                                : high while a burst owns the port
//   stat_beats [NUM_REQ*16]             : per-requester accepted-beat counters,
//                                         present only with RF_WB_ARB_STATS_EN defined
module regfile_wb_arbiter
  import regfile_wb_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ZERO_REG_RO = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         write_at_addr,
  output logic [DATA_W-1:0]         write_data,
`ifdef RF_WB_ARB_STATS_EN
  output logic [NUM_REQ*STAT_W-1:0] stat_beats,
`endif
  output logic                      busy
);
  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_e         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] rr_grant;
  logic [IDX_W-1:0]   rr_idx;

  logic [IDX_W-1:0]   acc_idx;
  logic               accept;
  logic               acc_last;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_data;
  logic [IDX_W-1:0]   next_ptr;
  logic               acc_zero;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  always_comb begin
    req_ready = '0;
    acc_idx   = owner;
    if (reset) begin
      if (state == ST_OWNED) begin
        req_ready[owner] = req_valid[owner];
      end else begin
        req_ready = rr_grant;
        acc_idx   = rr_idx;
      end
    end
  end

  assign accept   = |(req_valid & req_ready);
  assign acc_last = req_last[acc_idx];
  assign acc_addr = req_addr[int'(acc_idx)*ADDR_W +: ADDR_W];
  assign acc_data = req_data[int'(acc_idx)*DATA_W +: DATA_W];
  assign next_ptr = (int'(acc_idx) == NUM_REQ - 1) ? '0 : acc_idx + IDX_W'(1);
  // Register 0 is hard-wired: the beat completes its handshake but produces no write.
  assign acc_zero = (ZERO_REG_RO != 0) && (acc_addr == '0);
  assign busy     = (state == ST_OWNED);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      owner         <= '0;
      rr_ptr        <= '0;
      write_enable  <= 1'b0;
      write_at_addr <= '0;
      write_data    <= '0;
    end else begin
      write_enable <= accept && !acc_zero;
      if (accept) begin
        write_at_addr <= acc_addr;
        write_data    <= acc_data;
        case (state)
          ST_IDLE: begin
            if (acc_last) begin
              rr_ptr <= next_ptr;
            end else begin
              state <= ST_OWNED;
              owner <= acc_idx;
            end
          end
          ST_OWNED: begin
            if (acc_last) begin
              state  <= ST_IDLE;
              rr_ptr <= next_ptr;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef RF_WB_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else if (accept && (stat_cnt[acc_idx] != '1)) begin
      stat_cnt[acc_idx] <= stat_cnt[acc_idx] + STAT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_beats[g*STAT_W +: STAT_W] = stat_cnt[g];
  end
`endif
endmodule
